// File: rtl/bus_arbit_rr.sv
// bus_arbit_rr -- four-master round-robin bus arbiter with a bounded hold time.
//
// Ports:
//   clk       : sole clock; all state changes on its rising edge
//   reset     : asynchronous, active-high; drops any grant at once
//   m_req     : [3:0] request from masters M0..M3 (bit i = Mi)
//   m_grant   : [3:0] one-hot grant to the bus owner, zero when the bus is idle
//   bus_sel   : [1:0] index of the current (or most recent) owner, used as the mux select
//   bus_busy  : high while any grant bit is set
//
// Parameter:
//   MAX_HOLD  : cycles an owner may keep the bus while another master waits (1..255)
//
// All outputs come straight from registers, so a grant appears one clock after
// the request that won it is sampled.

module bus_arbit_rr #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] m_req,
    output logic [3:0] m_grant,
    output logic [1:0] bus_sel,
    output logic       bus_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state_reg, state_next;
    logic [1:0] last_reg, last_next;
    logic [7:0] hold_cnt_reg, hold_cnt_next;
    logic [3:0] grant_reg, grant_next;
    logic [1:0] sel_reg, sel_next;
    logic       busy_reg, busy_next;

    // Candidate search order: last+1, last+2, last+3, last (mod 4).
    logic [1:0] cand [4];
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
        assign cand[gi] = last_reg + 2'(gi + 1);
    end

    // The current owner is masked out of the search. grant_reg is one-hot for
    // the owner and zero in IDLE, so the same mask serves both states. Because
    // the owner is always at index last, it would be searched last anyway;
    // masking it makes preemption strictly hand the bus to someone else.
    logic [3:0] avail;
    logic       owner_req;
    assign avail     = m_req & ~grant_reg;
    assign owner_req = |(m_req & grant_reg);

    logic       win_found;
    logic [1:0] win_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        // Walk from lowest to highest priority so the highest-priority hit wins.
        for (int i = 3; i >= 0; i--) begin
            if (avail[cand[i]]) begin
                win_found = 1'b1;
                win_idx   = cand[i];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        hold_cnt_next = hold_cnt_reg;
        grant_next    = grant_reg;
        sel_next      = sel_reg;
        busy_next     = busy_reg;

        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    state_next    = OWNED;
                    grant_next    = 4'b0001 << win_idx;
                    sel_next      = win_idx;
                    last_next     = win_idx;
                    hold_cnt_next = 8'd1;
                    busy_next     = 1'b1;
                end
            end

            OWNED: begin
                if (owner_req && (!win_found || hold_cnt_reg < HOLD_LIMIT)) begin
                    // Owner keeps the bus; the counter saturates so a lone
                    // long-running owner never wraps back under the limit.
                    if (hold_cnt_reg != 8'hFF) begin
                        hold_cnt_next = hold_cnt_reg + 8'd1;
                    end
                end else if (win_found) begin
                    // Either the owner let go or its hold budget ran out:
                    // hand over on this edge with no idle cycle in between.
                    grant_next    = 4'b0001 << win_idx;
                    sel_next      = win_idx;
                    last_next     = win_idx;
                    hold_cnt_next = 8'd1;
                end else begin
                    // Nobody wants the bus; bus_sel and last keep the old owner.
                    state_next    = IDLE;
                    grant_next    = 4'b0000;
                    busy_next     = 1'b0;
                    hold_cnt_next = 8'd0;
                end
            end

            default: begin
                state_next    = IDLE;
                grant_next    = 4'b0000;
                busy_next     = 1'b0;
                hold_cnt_next = 8'd0;
            end
        endcase
    end

    // last resets to 3 so the first search starts at M0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            last_reg     <= 2'b11;
            hold_cnt_reg <= 8'd0;
            grant_reg    <= 4'b0000;
            sel_reg      <= 2'b00;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            hold_cnt_reg <= hold_cnt_next;
            grant_reg    <= grant_next;
            sel_reg      <= sel_next;
            busy_reg     <= busy_next;
        end
    end

    assign m_grant  = grant_reg;
    assign bus_sel  = sel_reg;
    assign bus_busy = busy_reg;

endmodule

// File: doc/bus_arbit_rr.md
BUS_ARBIT_RR -- requirements
Module: bus_arbit_rr

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum consecutive granted cycles while another master is requesting; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m_req  input  4  request from masters M0..M3; bit i = Mi.
REQ-005 m_grant  output  4  one-hot grant to the bus owner; all-zero when the bus is idle.
REQ-006 bus_sel  output  2  index of the current owner, driving the shared address/data mux select.
REQ-007 bus_busy  output  1  high while any grant is asserted.
REQ-008 All outputs SHALL be driven directly from registers.

Function
REQ-009 The FSM SHALL have two states: IDLE (no owner) and OWNED (exactly one grant bit high).
REQ-010 A round-robin pointer last[1:0] SHALL hold the index of the most recently granted master.
REQ-011 Winner selection SHALL search m_req starting at index last+1 (mod 4) upward with wrap, taking the first set bit.
REQ-012 IDLE, m_req==0: stay IDLE; outputs unchanged.
REQ-013 IDLE, m_req!=0: on the next edge go OWNED, grant the winner, set bus_sel and last to the winner, and load hold_cnt=1.
REQ-014 Grant latency SHALL be exactly one clock from a sampled request to m_grant high.
REQ-015 OWNED, owner req high, no other req: keep the grant; hold_cnt increments, saturating at 255.
REQ-016 OWNED, owner req high, other req pending, hold_cnt<MAX_HOLD: keep the grant; hold_cnt increments.
REQ-017 OWNED, owner req high, other req pending, hold_cnt>=MAX_HOLD: preempt on the next edge by granting the round-robin winner among the other requesters, excluding the current owner; hold_cnt=1.
REQ-018 OWNED, owner req low, others pending: hand over at the same edge to the round-robin winner, with no idle cycle; hold_cnt=1.
REQ-019 OWNED, owner req low, no others: go IDLE; m_grant=0; bus_busy=0; bus_sel and last keep their old value.
REQ-020 A preempted master SHALL re-arbitrate normally and has lowest priority immediately after preemption.
REQ-021 A request raised and dropped between edges, or dropped before being granted, SHALL have no effect.
REQ-022 m_grant SHALL never have more than one bit set; bus_busy SHALL equal the OR of m_grant in every cycle.
REQ-023 hold_cnt SHALL be 8 bits wide; MAX_HOLD comparison SHALL be unsigned.

Reset
REQ-024 While reset is high, the block SHALL hold: state=IDLE, m_grant=4'b0000, bus_sel=2'b00, bus_busy=0, hold_cnt=0, last=2'b11 so that M0 has first priority.
REQ-025 Reset asserted mid-ownership SHALL drop the grant immediately and asynchronously, without waiting for clk.
REQ-026 After reset deasserts, the first arbitration SHALL follow REQ-013.

Verification
REQ-027 Reset, then m_req=4'b1111 at edge 1 -> m_grant=0001, bus_sel=0 after edge 1; with MAX_HOLD=8, grant moves to 0010 exactly 8 cycles later.
REQ-028 M2 alone holds m_req for 20 cycles -> m_grant=0100 for all 20 cycles with no preemption; after M2 drops its request, m_grant=0000 and bus_sel stays 2.
REQ-029 Owner M1 drops its request while m_req=4'b1001 -> next edge m_grant=1000 (M3 wins over M0 by rotation), bus_busy stays 1.
REQ-030 Reset pulsed mid-cycle while M3 is owner -> m_grant=0000 and bus_busy=0 before the next clk edge; after release with m_req=1000, M3 is granted one edge later.
REQ-031 Run random m_req for 10k cycles -> m_grant is always one-hot or zero, and every continuously requesting master is granted within 3*MAX_HOLD+3 cycles.
